// File: rtl/insn_length_decoder.sv
// Byte-serial x86-64 instruction boundary finder: classifies each fetch byte and
// emits one registered record (length, opcode, map, ModRM, REX, prefixes) per instruction.
module insn_length_decoder #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         byte_valid,
    input  logic [7:0]   byte_in,
    output logic         byte_ready,
    input  logic [255:0] modrm_map,
    output logic         insn_valid,
    input  logic         insn_ready,
    output logic [3:0]   insn_len,
    output logic [7:0]   insn_opc,
    output logic [1:0]   insn_map,
    output logic         insn_has_modrm,
    output logic [7:0]   insn_modrm,
    output logic [3:0]   insn_rex,
    output logic         insn_opsz,
    output logic         insn_adsz,
    output logic         insn_lock,
    output logic [1:0]   insn_rep,
    output logic         insn_err
);

    localparam logic [3:0] LEN_LIMIT = 4'(MAX_LEN);

    typedef enum logic [2:0] {PFX, OPC2, OPC3, MODRM, SIB, DISP, IMM, HOLD} state_t;

    state_t     state, state_d, eff;
    logic [3:0] cnt_q, cnt_d, imm_q, imm_d, len_q, len_d;
    logic [7:0] opc_q, opc_d, modrm_q, modrm_d;
    logic [1:0] map_q, map_d, rep_q, rep_d;
    logic [3:0] rex_q, rex_d;
    logic       hasm_q, hasm_d, opsz_q, opsz_d, adsz_q, adsz_d, lock_q, lock_d;
    logic       accept, take, done, err, opc_seen, after_modrm;
    logic [3:0] dsp, im;

    function automatic logic [3:0] imm_len(input logic [1:0] map, input logic [7:0] opc,
                                           input logic opsz, input logic adsz,
                                           input logic rexw, input logic [2:0] regf);
        logic [3:0] z;
        z = opsz ? 4'd2 : 4'd4;
        imm_len = '0;
        if (map == 2'd0) begin
            case (opc) inside
                8'h04, 8'h0C, 8'h14, 8'h1C, 8'h24, 8'h2C, 8'h34, 8'h3C, 8'hA8,
                8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h83, [8'hB0:8'hB7],
                8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'hD4, 8'hD5, [8'hE0:8'hE7], 8'hEB:
                    imm_len = 4'd1;
                8'h05, 8'h0D, 8'h15, 8'h1D, 8'h25, 8'h2D, 8'h35, 8'h3D,
                8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9:
                    imm_len = z;
                8'hC2, 8'hCA:    imm_len = 4'd2;
                8'hC8:           imm_len = 4'd3;
                [8'hB8:8'hBF]:   imm_len = rexw ? 4'd8 : z;
                [8'hA0:8'hA3]:   imm_len = adsz ? 4'd4 : 4'd8;
                8'hF6:           imm_len = (regf[2:1] == 2'b00) ? 4'd1 : 4'd0;
                8'hF7:           imm_len = (regf[2:1] == 2'b00) ? z : 4'd0;
                default:         imm_len = '0;
            endcase
        end else if (map == 2'd1 && opc[7:4] == 4'h8) begin
            imm_len = 4'd4;
        end else if (map == 2'd3) begin
            imm_len = 4'd1;
        end
    endfunction

    function automatic logic modrm_present(input logic [1:0] map, input logic [7:0] opc,
                                           input logic [255:0] bitmap);
        case (map)
            2'd0:    modrm_present = bitmap[opc];
            2'd1:    modrm_present = !(opc == 8'h05 || opc == 8'h31 || opc == 8'hA2 ||
                                       opc[7:4] == 4'h8);
            default: modrm_present = 1'b1;
        endcase
    endfunction

    // HOLD with insn_ready high behaves as PFX so a new instruction starts bubble-free
    assign byte_ready = (state != HOLD) || insn_ready;
    assign accept     = byte_valid && byte_ready;
    assign take       = insn_valid && insn_ready;
    assign eff        = (state == HOLD) ? PFX : state;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt_q;
        imm_d       = imm_q;
        len_d       = len_q;
        opc_d       = opc_q;
        modrm_d     = modrm_q;
        map_d       = map_q;
        rep_d       = rep_q;
        rex_d       = rex_q;
        hasm_d      = hasm_q;
        opsz_d      = opsz_q;
        adsz_d      = adsz_q;
        lock_d      = lock_q;
        done        = 1'b0;
        err         = 1'b0;
        opc_seen    = 1'b0;
        after_modrm = 1'b0;
        dsp         = '0;
        im          = '0;
        if (state == HOLD && insn_ready) state_d = PFX;
        if (accept) begin
            len_d = len_q + 4'd1;
            case (eff)
                PFX: begin
                    case (byte_in) inside
                        8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: rex_d = '0;
                        8'h66:         begin opsz_d = 1'b1; rex_d = '0; end
                        8'h67:         begin adsz_d = 1'b1; rex_d = '0; end
                        8'hF0:         begin lock_d = 1'b1; rex_d = '0; end
                        8'hF2:         begin rep_d = 2'b10; rex_d = '0; end
                        8'hF3:         begin rep_d = 2'b11; rex_d = '0; end
                        [8'h40:8'h4F]: rex_d = byte_in[3:0];
                        8'h0F:         begin map_d = 2'd1; state_d = OPC2; end
                        default:       opc_seen = 1'b1;
                    endcase
                end
                OPC2: begin
                    if (byte_in == 8'h38) begin
                        map_d   = 2'd2;
                        state_d = OPC3;
                    end else if (byte_in == 8'h3A) begin
                        map_d   = 2'd3;
                        state_d = OPC3;
                    end else begin
                        opc_seen = 1'b1;
                    end
                end
                OPC3: opc_seen = 1'b1;
                MODRM: begin
                    modrm_d = byte_in;
                    imm_d   = imm_len(map_q, opc_q, opsz_q, adsz_q, rex_q[3], byte_in[5:3]);
                    if (byte_in[7:6] != 2'd3 && byte_in[2:0] == 3'd4) begin
                        state_d = SIB;
                    end else begin
                        after_modrm = 1'b1;
                        if (byte_in[7:6] == 2'd1)
                            dsp = 4'd1;
                        else if (byte_in[7:6] == 2'd2 ||
                                 (byte_in[7:6] == 2'd0 && byte_in[2:0] == 3'd5))
                            dsp = 4'd4;
                    end
                end
                SIB: begin
                    after_modrm = 1'b1;
                    if (modrm_q[7:6] == 2'd1)
                        dsp = 4'd1;
                    else if (modrm_q[7:6] == 2'd2 || byte_in[2:0] == 3'd5)
                        dsp = 4'd4;
                end
                DISP: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (imm_q != 4'd0) begin
                            state_d = IMM;
                            cnt_d   = imm_q;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                IMM: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) done = 1'b1;
                end
                default: ;
            endcase
            if (opc_seen) begin
                opc_d  = byte_in;
                hasm_d = modrm_present(map_d, byte_in, modrm_map);
                if (hasm_d) begin
                    state_d = MODRM;
                end else begin
                    im    = imm_len(map_d, byte_in, opsz_q, adsz_q, rex_q[3], 3'd0);
                    imm_d = im;
                    if (im != 4'd0) begin
                        state_d = IMM;
                        cnt_d   = im;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            if (after_modrm) begin
                if (dsp != 4'd0) begin
                    state_d = DISP;
                    cnt_d   = dsp;
                end else if (imm_d != 4'd0) begin
                    state_d = IMM;
                    cnt_d   = imm_d;
                end else begin
                    done = 1'b1;
                end
            end
            if (!done && len_d == LEN_LIMIT) begin
                done = 1'b1;
                err  = 1'b1;
            end
            if (done) state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= PFX;
            cnt_q          <= '0;
            imm_q          <= '0;
            len_q          <= '0;
            opc_q          <= '0;
            modrm_q        <= '0;
            map_q          <= '0;
            rep_q          <= '0;
            rex_q          <= '0;
            hasm_q         <= 1'b0;
            opsz_q         <= 1'b0;
            adsz_q         <= 1'b0;
            lock_q         <= 1'b0;
            insn_valid     <= 1'b0;
            insn_len       <= '0;
            insn_opc       <= '0;
            insn_map       <= '0;
            insn_has_modrm <= 1'b0;
            insn_modrm     <= '0;
            insn_rex       <= '0;
            insn_opsz      <= 1'b0;
            insn_adsz      <= 1'b0;
            insn_lock      <= 1'b0;
            insn_rep       <= '0;
            insn_err       <= 1'b0;
        end else begin
            state <= state_d;
            if (done) begin
                insn_valid     <= 1'b1;
                insn_len       <= len_d;
                insn_opc       <= opc_d;
                insn_map       <= map_d;
                insn_has_modrm <= hasm_d;
                insn_modrm     <= modrm_d;
                insn_rex       <= rex_d;
                insn_opsz      <= opsz_d;
                insn_adsz      <= adsz_d;
                insn_lock      <= lock_d;
                insn_rep       <= rep_d;
                insn_err       <= err;
                cnt_q          <= '0;
                imm_q          <= '0;
                len_q          <= '0;
                opc_q          <= '0;
                modrm_q        <= '0;
                map_q          <= '0;
                rep_q          <= '0;
                rex_q          <= '0;
                hasm_q         <= 1'b0;
                opsz_q         <= 1'b0;
                adsz_q         <= 1'b0;
                lock_q         <= 1'b0;
            end else begin
                if (take) insn_valid <= 1'b0;
                cnt_q   <= cnt_d;
                imm_q   <= imm_d;
                len_q   <= len_d;
                opc_q   <= opc_d;
                modrm_q <= modrm_d;
                map_q   <= map_d;
                rep_q   <= rep_d;
                rex_q   <= rex_d;
                hasm_q  <= hasm_d;
                opsz_q  <= opsz_d;
                adsz_q  <= adsz_d;
                lock_q  <= lock_d;
            end
        end
    end

endmodule

// File: tb/tb_insn_length_decoder.sv
// Scoreboard bench for insn_length_decoder: expected records are queued as byte
// streams are driven and compared when the decoder hands a record downstream.
module tb_insn_length_decoder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         byte_valid;
    logic [7:0]   byte_in;
    logic         byte_ready;
    logic [255:0] modrm_map;
    logic         insn_valid;
    logic         insn_ready;
    logic [3:0]   insn_len;
    logic [7:0]   insn_opc;
    logic [1:0]   insn_map;
    logic         insn_has_modrm;
    logic [7:0]   insn_modrm;
    logic [3:0]   insn_rex;
    logic         insn_opsz;
    logic         insn_adsz;
    logic         insn_lock;
    logic [1:0]   insn_rep;
    logic         insn_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] rec_q[$];
    logic [7:0]  bq[$];

    insn_length_decoder #(.MAX_LEN(15)) dut (
        .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(byte_ready), .modrm_map(modrm_map), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .insn_len(insn_len), .insn_opc(insn_opc),
        .insn_map(insn_map), .insn_has_modrm(insn_has_modrm), .insn_modrm(insn_modrm),
        .insn_rex(insn_rex), .insn_opsz(insn_opsz), .insn_adsz(insn_adsz),
        .insn_lock(insn_lock), .insn_rep(insn_rep), .insn_err(insn_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic [3:0] l, input logic [7:0] o,
                                         input logic [1:0] m, input logic h,
                                         input logic [7:0] mr, input logic [3:0] rx,
                                         input logic os, input logic as, input logic lk,
                                         input logic [1:0] rp, input logic er);
        return {31'd0, l, o, m, h, mr, rx, os, as, lk, rp, er};
    endfunction

    function automatic logic [63:0] dut_rec();
        return pack(insn_len, insn_opc, insn_map, insn_has_modrm, insn_modrm, insn_rex,
                    insn_opsz, insn_adsz, insn_lock, insn_rep, insn_err);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && insn_valid && insn_ready) begin
            if (rec_q.size() == 0) check("unexpected_record", dut_rec(), '1);
            else check("record", dut_rec(), rec_q.pop_front());
        end
    end

    // Drive one byte and return after the edge that accepts it.
    task automatic put(input logic [7:0] b, output int waits);
        byte_valid = 1'b1;
        byte_in    = b;
        waits      = 0;
        @(negedge clk);
        while (!byte_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!byte_ready) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send();
        int w;
        for (int i = 0; i < bq.size(); i++) put(bq[i], w);
    endtask

    initial begin
        int w;
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        insn_ready = 1'b1;
        modrm_map  = '0;
        modrm_map[8'h89] = 1'b1;
        modrm_map[8'h8B] = 1'b1;
        modrm_map[8'hF7] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_byte_ready", 64'(byte_ready), 64'd1);
        check("reset_insn_valid", 64'(insn_valid), 64'd0);
        check("reset_record", dut_rec(), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // mov rbp,rsp: valid rises right after the ModRM byte
        rec_q.push_back(pack(4'd3, 8'h89, 2'd0, 1'b1, 8'hE5, 4'h8, 0, 0, 0, 2'b00, 0));
        put(8'h48, w);
        put(8'h89, w);
        check("valid_before_last", 64'(insn_valid), 64'd0);
        put(8'hE5, w);
        check("valid_after_last", 64'(insn_valid), 64'd1);

        // mov ax,imm16 followed immediately by ret
        rec_q.push_back(pack(4'd4, 8'hB8, 2'd0, 1'b0, 8'h00, 4'h0, 1, 0, 0, 2'b00, 0));
        rec_q.push_back(pack(4'd1, 8'hC3, 2'd0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'h66, 8'hB8, 8'h34};
        send();
        put(8'h12, w);
        put(8'hC3, w);
        check("no_bubble_waits", 64'(w), 64'd0);
        check("valid_after_ret", 64'(insn_valid), 64'd1);

        rec_q.push_back(pack(4'd7, 8'h8B, 2'd0, 1'b1, 8'h84, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'h8B, 8'h84, 8'h24, 8'h10, 8'h00, 8'h00, 8'h00};
        send();
        rec_q.push_back(pack(4'd7, 8'h8B, 2'd0, 1'b1, 8'h04, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'h8B, 8'h04, 8'h25, 8'h00, 8'h10, 8'h00, 8'h00};
        send();
        rec_q.push_back(pack(4'd5, 8'h0F, 2'd3, 1'b1, 8'hC1, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'h0F, 8'h3A, 8'h0F, 8'hC1, 8'h08};
        send();
        rec_q.push_back(pack(4'd6, 8'h85, 2'd1, 1'b0, 8'h00, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'h0F, 8'h85, 8'h00, 8'h01, 8'h00, 8'h00};
        send();
        rec_q.push_back(pack(4'd6, 8'hF7, 2'd0, 1'b1, 8'hC0, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'hF7, 8'hC0, 8'h78, 8'h56, 8'h34, 8'h12};
        send();
        rec_q.push_back(pack(4'd2, 8'hF7, 2'd0, 1'b1, 8'hD8, 4'h0, 0, 0, 0, 2'b00, 0));
        bq = '{8'hF7, 8'hD8};
        send();

        // 15 prefixes overflow the length limit; the next byte starts fresh
        rec_q.push_back(pack(4'd15, 8'h00, 2'd0, 1'b0, 8'h00, 4'h0, 1, 0, 0, 2'b00, 1));
        rec_q.push_back(pack(4'd1, 8'h90, 2'd0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 2'b00, 0));
        for (int i = 0; i < 15; i++) put(8'h66, w);
        put(8'h90, w);

        // downstream stall: record must hold and no bytes accepted
        @(posedge clk);
        #1;
        insn_ready = 1'b0;
        rec_q.push_back(pack(4'd1, 8'hC3, 2'd0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 2'b00, 0));
        put(8'hC3, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_byte_ready", 64'(byte_ready), 64'd0);
            check("stall_valid", 64'(insn_valid), 64'd1);
            check("stall_record", dut_rec(), pack(4'd1, 8'hC3, 2'd0, 1'b0, 8'h00, 4'h0,
                                                  0, 0, 0, 2'b00, 0));
        end
        @(posedge clk);
        #1;
        insn_ready = 1'b1;
        @(negedge clk);
        check("take_byte_ready", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;

        // reset in the middle of an instruction
        put(8'h8B, w);
        put(8'h84, w);
        reset_n = 1'b0;
        #2;
        check("midreset_valid", 64'(insn_valid), 64'd0);
        check("midreset_byte_ready", 64'(byte_ready), 64'd1);
        check("midreset_record", dut_rec(), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("postreset_no_record", 64'(insn_valid), 64'd0);
        rec_q.push_back(pack(4'd1, 8'h90, 2'd0, 1'b0, 8'h00, 4'h0, 0, 0, 0, 2'b00, 0));
        put(8'h90, w);

        for (int i = 0; i < 50 && rec_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(rec_q.size()), 64'd0);
        check("final_valid", 64'(insn_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_length_decoder.md
# insn_length_decoder

- Byte-serial x86-64 instruction boundary finder.
- Sits between the fetch byte queue and the opcode/ModRM decode tables.
- Consumes one instruction byte per cycle and classifies it as prefix, REX, opcode, ModRM, SIB, displacement or immediate.
- At the end of each instruction, presents one registered record: length, opcode, map, ModRM, REX and prefix flags. The decode stage uses this record to index its mnemonic table.

## Interface
- `MAX_LEN`, default 15: architectural instruction length limit in bytes.
- `clk`, in, 1: rising-edge clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `byte_valid`, in, 1: `byte_in` holds a fetch byte.
- `byte_in`, in, 8: next instruction byte.
- `byte_ready`, out, 1: byte accepted when `byte_valid && byte_ready`.
- `modrm_map`, in, 256: one-byte-map ModRM-present bitmap, indexed by opcode; bit `n` is opcode `n`.
- `insn_valid`, out, 1: instruction record valid.
- `insn_ready`, in, 1: downstream takes the record when `insn_valid && insn_ready`.
- `insn_len`, out, 4: total bytes, 1..15.
- `insn_opc`, out, 8: final opcode byte.
- `insn_map`, out, 2: opcode map; 0 = one-byte, 1 = 0F, 2 = 0F38, 3 = 0F3A.
- `insn_has_modrm`, out, 1: ModRM byte is present.
- `insn_modrm`, out, 8: the ModRM byte; 0 when none.
- `insn_rex`, out, 4: REX.WRXB; 0 when no REX.
- `insn_opsz`, out, 1: 66 prefix seen.
- `insn_adsz`, out, 1: 67 prefix seen.
- `insn_lock`, out, 1: F0 prefix seen.
- `insn_rep`, out, 2: last of F2/F3 seen; 00 none, 10 = F2, 11 = F3.
- `insn_err`, out, 1: length limit exceeded.

## Operation

**State machine**
- States: PFX, OPC2, OPC3, MODRM, SIB, DISP, IMM, HOLD.
- PFX:
  - 26/2E/36/3E/64/65: consumed; no flag output.
  - 66, 67, F0, F2, F3: set their respective flags.
  - 40–4F: latch REX.
  - A legacy prefix after a REX clears the latched REX.
  - 0F goes to OPC2.
  - Any other byte is a one-byte opcode.
- OPC2:
  - 38 or 3A goes to OPC3 with map 2 or 3.
  - Otherwise the byte is the opcode, map 1.
- OPC3: the byte is the opcode.

**ModRM presence**
- Map 0: `modrm_map[opc]`.
- Map 1: present except opcodes 05, 31, A2 and 80–8F.
- Maps 2 and 3: always present.

**ModRM decode** (mod = bits 7:6, rm = bits 2:0)
- SIB follows if mod != 3 and rm == 4.
- Displacement:
  - mod == 1: 1 byte.
  - mod == 2: 4 bytes.
  - mod == 0 and rm == 5: 4 bytes.
  - mod == 0 and SIB.base == 5: 4 bytes.

**Immediate bytes, map 0** ("z" = 2 if 66 seen, else 4)
- 1 byte:
  - 04, 0C, 14, 1C, 24, 2C, 34, 3C, A8
  - 6A, 6B, 70–7F, 80, 83, B0–B7
  - C0, C1, C6, CD, D4, D5, E0–E7, EB
- z bytes: 05, 0D, 15, 1D, 25, 2D, 35, 3D, 68, 69, 81, A9, C7, E8, E9.
- C2, CA: 2 bytes.
- C8: 3 bytes.
- B8–BF: 8 if REX.W, else z.
- A0–A3: 4 if 67 seen, else 8.
- F6 with ModRM.reg in {0,1}: 1 byte.
- F7 with ModRM.reg in {0,1}: z bytes.
- All other map-0 opcodes: 0.

**Immediate bytes, other maps**
- Map 1, 80–8F: 4.
- Map 3: 1.
- Otherwise 0.

**Byte counting**
- A single down-counter loads the displacement count, then the immediate count.
- States with a zero count are skipped.
- A 4-bit length counter increments on every accepted byte.

## Timing
**Reset values**
- `byte_ready` = 1; `insn_valid` = 0.
- All record fields = 0.
- State = PFX; counters = 0.

**Record timing and flow control**
- The record is registered. `insn_valid` rises the cycle after the last byte of the instruction is accepted.
- HOLD keeps `byte_ready` = 0 until `insn_valid && insn_ready`.
- In the cycle the record is taken, `byte_ready` = 1 and the FSM is in PFX.
- Back-to-back throughput = 1 byte/cycle, plus 0 bubble cycles when `insn_ready` is held at 1.
- `byte_valid` low: the FSM holds its state and the counters.

**Length limit**
- If the 15th byte is accepted and the instruction is still incomplete:
  - emit a record with `insn_err` = 1 and `insn_len` = 15;
  - discard the remainder;
  - restart in PFX at the next byte.
- No 16th byte is ever counted.

**Reset during operation**
- Asserting `reset_n` low mid-instruction aborts it immediately.
- No partial record is emitted.

## Test plan
- 48 89 E5 (mov rbp,rsp), `modrm_map[89]` = 1, `insn_ready` = 1: one record with len 3, opc 89, map 0, modrm E5, rex 8; `insn_valid` rises the cycle after the E5 byte.
- 66 B8 34 12: len 4, opsz 1, opc B8. The following byte, C3, yields a separate record with len 1 and no bubble.
- 8B 84 24 10 00 00 00 (SIB + disp32): len 7, modrm 84. Same with 8B 04 25 …: base 5 gives disp32, len 7.
- 0F 3A 0F C1 08 (palignr): map 3, len 5, modrm C1. Also 0F 85 + 4 bytes: map 1, len 6, has_modrm 0.
- F7 C0 78 56 34 12 gives len 6. F7 D8 (neg) gives len 2.
- 15 × 66 then 90: record with err 1 and len 15; 90 then produces its own len-1 record.
- `insn_ready` = 0 for 5 cycles after a record: `byte_ready` stays 0 and the record stays stable.
- `reset_n` low mid-instruction: no record is emitted and outputs return to reset values.
